// File: rtl/control_unit_pkg.sv
// Shared encodings for the instruction decoder: opcodes, function codes,
// ALU operations, next-PC selects and the packed control bundle.
package control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SHIFT = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001010;
    localparam logic [5:0] OP_XORI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b001111;
    localparam logic [5:0] OP_BNE   = 6'b010000;
    localparam logic [5:0] OP_J     = 6'b010010;

    localparam logic [5:0] FUNC_ADD = 6'b000001;
    localparam logic [5:0] FUNC_SUB = 6'b000010;
    localparam logic [5:0] FUNC_AND = 6'b000011;
    localparam logic [5:0] FUNC_OR  = 6'b000100;
    localparam logic [5:0] FUNC_XOR = 6'b000101;

    localparam logic [5:0] FUNC_SLL = 6'b000001;
    localparam logic [5:0] FUNC_SRL = 6'b000010;
    localparam logic [5:0] FUNC_SRA = 6'b000011;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_XOR = 3'b100;
    localparam logic [2:0] ALUC_SLL = 3'b101;
    localparam logic [2:0] ALUC_SRL = 3'b110;
    localparam logic [2:0] ALUC_SRA = 3'b111;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_RSVD   = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic [2:0] aluc;
        logic       regrt;
        logic       aluimm;
        logic       sext;
        logic [1:0] pcsource;
        logic       shift;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decode: op/func/rsrtequ to the control bundle.
// Anything not recognised falls through to the all-zero NOP bundle.
module control_decode
    import control_unit_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       rsrtequ,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_RTYPE: begin
                ctrl.wreg = 1'b1;
                case (func)
                    FUNC_ADD: ctrl.aluc = ALUC_ADD;
                    FUNC_SUB: ctrl.aluc = ALUC_SUB;
                    FUNC_AND: ctrl.aluc = ALUC_AND;
                    FUNC_OR:  ctrl.aluc = ALUC_OR;
                    FUNC_XOR: ctrl.aluc = ALUC_XOR;
                    default:  ctrl = '0;
                endcase
            end
            OP_SHIFT: begin
                ctrl.wreg  = 1'b1;
                ctrl.shift = 1'b1;
                case (func)
                    FUNC_SLL: ctrl.aluc = ALUC_SLL;
                    FUNC_SRL: ctrl.aluc = ALUC_SRL;
                    FUNC_SRA: ctrl.aluc = ALUC_SRA;
                    default:  ctrl = '0;
                endcase
            end
            OP_ADDI: begin
                ctrl.wreg   = 1'b1;
                ctrl.regrt  = 1'b1;
                ctrl.aluimm = 1'b1;
                ctrl.sext   = 1'b1;
                ctrl.aluc   = ALUC_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.wreg   = 1'b1;
                ctrl.regrt  = 1'b1;
                ctrl.aluimm = 1'b1;
                ctrl.aluc   = (op == OP_ANDI) ? ALUC_AND :
                              (op == OP_ORI)  ? ALUC_OR  : ALUC_XOR;
            end
            OP_LW: begin
                ctrl.wreg   = 1'b1;
                ctrl.m2reg  = 1'b1;
                ctrl.regrt  = 1'b1;
                ctrl.aluimm = 1'b1;
                ctrl.sext   = 1'b1;
                ctrl.aluc   = ALUC_ADD;
            end
            OP_SW: begin
                ctrl.wmem   = 1'b1;
                ctrl.aluimm = 1'b1;
                ctrl.sext   = 1'b1;
                ctrl.aluc   = ALUC_ADD;
            end
            // Branch compare result only steers the next-PC select.
            OP_BEQ: begin
                ctrl.sext     = 1'b1;
                ctrl.aluc     = ALUC_SUB;
                ctrl.pcsource = rsrtequ ? PCSRC_BRANCH : PCSRC_PC4;
            end
            OP_BNE: begin
                ctrl.sext     = 1'b1;
                ctrl.aluc     = ALUC_SUB;
                ctrl.pcsource = rsrtequ ? PCSRC_PC4 : PCSRC_BRANCH;
            end
            OP_J: begin
                ctrl.pcsource = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Decode-to-execute control register: decodes op/func/rsrtequ each cycle
// and presents the control bundle one clock later.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rsrtequ,
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       wreg,
    output logic       m2reg,
    output logic       wmem,
    output logic [2:0] aluc,
    output logic       regrt,
    output logic       aluimm,
    output logic       sext,
    output logic [1:0] pcsource,
    output logic       shift
);

    ctrl_t ctrl_p0;
    ctrl_t ctrl_p1;

    control_decode u_decode (
        .op      (op),
        .func    (func),
        .rsrtequ (rsrtequ),
        .ctrl    (ctrl_p0)
    );

    // Stage p0 -> p1: decode result captured; reset clears the whole bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_p1 <= '0;
        end else begin
            ctrl_p1 <= ctrl_p0;
        end
    end

    assign wreg     = ctrl_p1.wreg;
    assign m2reg    = ctrl_p1.m2reg;
    assign wmem     = ctrl_p1.wmem;
    assign aluc     = ctrl_p1.aluc;
    assign regrt    = ctrl_p1.regrt;
    assign aluimm   = ctrl_p1.aluimm;
    assign sext     = ctrl_p1.sext;
    assign pcsource = ctrl_p1.pcsource;
    assign shift    = ctrl_p1.shift;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; expected bundles are hand-written as
// {wreg,m2reg,wmem,aluc[2:0],regrt,aluimm,sext,pcsource[1:0],shift}.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       rsrtequ;
    logic [5:0] op;
    logic [5:0] func;
    logic       wreg, m2reg, wmem, regrt, aluimm, sext, shift;
    logic [2:0] aluc;
    logic [1:0] pcsource;

    int checks = 0;
    int passes = 0;

    control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .rsrtequ  (rsrtequ),
        .op       (op),
        .func     (func),
        .wreg     (wreg),
        .m2reg    (m2reg),
        .wmem     (wmem),
        .aluc     (aluc),
        .regrt    (regrt),
        .aluimm   (aluimm),
        .sext     (sext),
        .pcsource (pcsource),
        .shift    (shift)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {wreg, m2reg, wmem, aluc, regrt, aluimm, sext, pcsource, shift};
    endfunction

    task automatic check(input string tag, input logic [11:0] expv);
        logic [11:0] obs;
        obs = observed();
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    // Drive inputs away from the rising edge, then sample just after it.
    task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                        input logic eq, input logic [11:0] expv);
        @(negedge clk);
        op = o;
        func = f;
        rsrtequ = eq;
        @(posedge clk);
        #1;
        check(tag, expv);
    endtask

    initial begin
        rst = 1'b1;
        op = 6'b001101;
        func = 6'b000000;
        rsrtequ = 1'b0;
        #1;
        check("reset_before_edge", 12'b0_0_0_000_0_0_0_00_0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_held", 12'b0_0_0_000_0_0_0_00_0);
        @(negedge clk);
        rst = 1'b0;

        step("r_add",  6'b000000, 6'b000001, 1'b0, 12'b1_0_0_000_0_0_0_00_0);
        step("r_sub",  6'b000000, 6'b000010, 1'b1, 12'b1_0_0_001_0_0_0_00_0);
        step("r_and",  6'b000000, 6'b000011, 1'b0, 12'b1_0_0_010_0_0_0_00_0);
        step("r_or",   6'b000000, 6'b000100, 1'b0, 12'b1_0_0_011_0_0_0_00_0);
        step("r_xor",  6'b000000, 6'b000101, 1'b0, 12'b1_0_0_100_0_0_0_00_0);
        step("sh_sll", 6'b000010, 6'b000001, 1'b0, 12'b1_0_0_101_0_0_0_00_1);
        step("sh_srl", 6'b000010, 6'b000010, 1'b0, 12'b1_0_0_110_0_0_0_00_1);
        step("sh_sra", 6'b000010, 6'b000011, 1'b1, 12'b1_0_0_111_0_0_0_00_1);
        step("addi",   6'b000101, 6'b000000, 1'b0, 12'b1_0_0_000_1_1_1_00_0);
        step("andi",   6'b001001, 6'b000000, 1'b0, 12'b1_0_0_010_1_1_0_00_0);
        step("ori_func_ignored", 6'b001010, 6'b111111, 1'b1, 12'b1_0_0_011_1_1_0_00_0);
        step("xori",   6'b001100, 6'b000011, 1'b0, 12'b1_0_0_100_1_1_0_00_0);
        step("lw",     6'b001101, 6'b000000, 1'b0, 12'b1_1_0_000_1_1_1_00_0);
        step("sw",     6'b001110, 6'b000000, 1'b1, 12'b0_0_1_000_0_1_1_00_0);
        step("beq_taken",    6'b001111, 6'b000000, 1'b1, 12'b0_0_0_001_0_0_1_01_0);
        step("beq_nottaken", 6'b001111, 6'b000000, 1'b0, 12'b0_0_0_001_0_0_1_00_0);
        step("bne_taken",    6'b010000, 6'b000000, 1'b0, 12'b0_0_0_001_0_0_1_01_0);
        step("bne_nottaken", 6'b010000, 6'b000001, 1'b1, 12'b0_0_0_001_0_0_1_00_0);
        step("jump",         6'b010010, 6'b000000, 1'b0, 12'b0_0_0_000_0_0_0_11_0);
        step("jump_eq1",     6'b010010, 6'b000101, 1'b1, 12'b0_0_0_000_0_0_0_11_0);
        step("ill_op",       6'b111111, 6'b000001, 1'b1, 12'b0_0_0_000_0_0_0_00_0);
        step("r_after_nop",  6'b000000, 6'b000001, 1'b0, 12'b1_0_0_000_0_0_0_00_0);
        step("ill_rfunc",    6'b000000, 6'b111111, 1'b0, 12'b0_0_0_000_0_0_0_00_0);
        step("ill_rfunc0",   6'b000000, 6'b000000, 1'b0, 12'b0_0_0_000_0_0_0_00_0);
        step("ill_shfunc",   6'b000010, 6'b000100, 1'b0, 12'b0_0_0_000_0_0_0_00_0);
        step("ill_op_gap",   6'b000001, 6'b000001, 1'b0, 12'b0_0_0_000_0_0_0_00_0);

        // Outputs must hold between rising edges even when inputs change.
        step("lw_again", 6'b001101, 6'b000000, 1'b0, 12'b1_1_0_000_1_1_1_00_0);
        @(negedge clk);
        op = 6'b111111;
        #1;
        check("hold_mid_cycle", 12'b1_1_0_000_1_1_1_00_0);
        @(posedge clk);
        #1;
        check("nop_after_edge", 12'b0_0_0_000_0_0_0_00_0);

        // Asynchronous reset mid-stream clears without a clock edge.
        step("beq_pre_rst", 6'b001111, 6'b000000, 1'b1, 12'b0_0_0_001_0_0_1_01_0);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", 12'b0_0_0_000_0_0_0_00_0);
        @(posedge clk);
        #1;
        check("reset_ignores_edge", 12'b0_0_0_000_0_0_0_00_0);
        @(negedge clk);
        rst = 1'b0;
        op = 6'b000101;
        func = 6'b000000;
        rsrtequ = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_reset", 12'b1_0_0_000_1_1_1_00_0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
